state_code_decoder: RTL and testbench
=====================================

# state_code_decoder

Receive-side counterpart of the team's 2-bit state-code transmitter FSM. The transmitter emits one code per clock: I (01) while in or just out of reset, then S (10) or T (11), and it toggles between S and T whenever its serial input is 1. This block samples that code stream, recovers the serial bit stream and checks protocol legality. It packs recovered bits LSB-first into WIDTH-bit words and presents them on a valid/ready output port, alongside error and overflow status.

## Interface
- WIDTH, 8, recovered word width in bits (2..32)
- ERR_CNT_W, 8, width of the saturating error and overflow counters
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- code_in  in  2  transmitter state code, sampled every cycle
- clear  in  1  synchronous; zeroes err_count, ovf_count, ovf_sticky
- word_data  out  WIDTH  recovered word; bit 0 is the first recovered bit
- word_valid  out  1  word_data holds an unconsumed word
- word_ready  in  1  consumer accepts the word when word_valid && word_ready at posedge
- locked  out  1  decoder is in RUN
- err  out  1  decoder is in ERR
- resync  out  1  one-cycle pulse when I is seen while in RUN
- err_count  out  ERR_CNT_W  entries into ERR, saturating
- ovf_count  out  ERR_CNT_W  words dropped on overflow, saturating
- ovf_sticky  out  1  set on any overflow; cleared by clear or reset

## Operation
- Registers:
  - prev_code: code_in delayed by one cycle.
  - shift register sr[WIDTH-1:0] and bit counter bcnt (0..WIDTH-1).
  - output holding register: word_data plus word_valid.
- Decoder states (state after the edge that samples code_in):
  - HUNT (reset state):
    - 01 → ARMED.
    - 00, 10, 11 → stay in HUNT; no error.
  - ARMED:
    - 01 → stay in ARMED.
    - 10 → RUN. No bit is recovered; I→S is unconditional on the transmitter side.
    - 11 or 00 → ERR.
  - RUN:
    - prev_code ∈ {10,11} and code_in ∈ {10,11} → recover bit b = (code_in != prev_code).
    - 01 → ARMED; pulse resync; clear sr and bcnt (partial word discarded).
    - 00 → ERR.
  - ERR:
    - 01 → ARMED.
    - Any other code → stay in ERR.
    - sr and bcnt are cleared on entry.
  - Every entry into ERR increments err_count, saturating at all-ones.
- Bit packing: sr[bcnt] <= b and bcnt <= bcnt+1. When bcnt == WIDTH-1, the word {b, sr[WIDTH-2:0]} completes and bcnt wraps to 0.
- Completion, at the same edge:
  - Holding register empty, or being accepted at this edge → load word_data and keep or set word_valid.
  - Holding register full and not accepted → drop the new word, set ovf_sticky, increment ovf_count (saturating). The held word is unchanged.
- Acceptance with no completion at the same edge → word_valid <= 0. word_data is unchanged.
- Accepted words are never lost or duplicated. An error or resync does not disturb a word already held.
- clear and an increment on the same edge: clear wins and the counter ends at 0.

## Timing
- Reset values:
  - state HUNT; prev_code 00; sr 0; bcnt 0.
  - word_data 0; word_valid 0; locked 0; err 0; resync 0.
  - err_count 0; ovf_count 0; ovf_sticky 0.
- locked, err and resync are registered and reflect the state after the sampling edge.
- Latency: the code that completes bit WIDTH-1 is sampled at edge k; word_valid is high from edge k.
- With ready held high, one word is delivered every WIDTH cycles with no bubble.
- Reset mid-word discards the partial word and any held word.
- After reset, the first word needs at least 2+WIDTH codes: 01, 10, then WIDTH data codes.

## Structure
- Package state_code_pkg holds:
  - localparams CODE_NONE=2'b00, CODE_I=2'b01, CODE_S=2'b10, CODE_T=2'b11.
  - decoder state enum {HUNT, ARMED, RUN, ERR}.
  - The transmitter is expected to adopt the same constants.
- Sub-module state_code_packer holds sr, bcnt, the holding register, the valid/ready handshake and overflow counting. Its inputs are bit, bit_en and flush.
- The top level holds the decoder FSM, prev_code and err_count.

## Test plan
- Basic decode: reset, then codes 01,10,11,11,10,10,10,11,11,10 with ready=1 → word_data=0xA5 and word_valid for one cycle; err=0; locked=1.
- Back-pressure: ready=0 while two full words are sent → first word held unchanged, ovf_sticky=1, ovf_count=1. Then ready=1 → first word accepted, word_valid=0.
- Accept and complete on the same edge: ready pulses exactly on the completion edge of word 2 → word_valid stays 1, word_data=word 2, ovf_count=0.
- Illegal codes:
  - 00 in RUN → err=1 and err_count=1.
  - 11 directly after 01 → err_count=2.
  - Then 01,10 → locked=1 and err=0.
- Resync: 01 after 3 data bits → resync pulse, partial word discarded; the next 8 bits form a clean word.
- Edge cases:
  - Async reset asserted mid-word → all outputs return to reset values immediately.
  - clear asserted on the same edge as an error → err_count=0.
  - 300 errors with ERR_CNT_W=8 → err_count saturates at 255.

Source files
------------

// File: rtl/state_code_pkg.sv
// Shared code constants and decoder state type for the 2-bit state-code link.
// The transmitter FSM is expected to use the same constants.
package state_code_pkg;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_I    = 2'b01;
  localparam logic [1:0] CODE_S    = 2'b10;
  localparam logic [1:0] CODE_T    = 2'b11;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } dec_state_e;

  // S and T are the only codes that carry data once the link is running.
  function automatic logic is_data_code(input logic [1:0] code);
    return (code == CODE_S) || (code == CODE_T);
  endfunction

endpackage

// File: rtl/state_code_decoder_if.sv
// Recovered-word valid/ready port between the decoder and its consumer.
// The master drives data and valid; the slave returns ready.
interface state_code_decoder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/state_code_packer.sv
// Packs recovered bits LSB-first into WIDTH-bit words and holds one word for a
// valid/ready consumer; a word completing while the holder is full is dropped.
module state_code_packer #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_val,
  input  logic                 bit_en,
  input  logic                 flush,
  input  logic                 clear,
  state_code_decoder_if.master word,
  output logic [ERR_CNT_W-1:0] ovf_count,
  output logic                 ovf_sticky
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic [ERR_CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic                 complete;
  logic [WIDTH-1:0]     new_word;

  always_comb begin
    sr_d         = sr_q;
    bcnt_d       = bcnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    ovf_count_d  = ovf_count_q;
    ovf_sticky_d = ovf_sticky_q;
    complete     = 1'b0;
    new_word     = sr_q;

    if (flush) begin
      sr_d   = '0;
      bcnt_d = '0;
    end else if (bit_en) begin
      if (bcnt_q == LAST) begin
        complete = 1'b1;
        new_word = {bit_val, sr_q[WIDTH-2:0]};
        sr_d     = '0;
        bcnt_d   = '0;
      end else begin
        sr_d[bcnt_q] = bit_val;
        bcnt_d       = bcnt_q + BW'(1);
      end
    end

    // A completion on the accepting edge refills the holder with no bubble.
    if (complete) begin
      if (!valid_q || word.word_ready) begin
        data_d  = new_word;
        valid_d = 1'b1;
      end else begin
        ovf_sticky_d = 1'b1;
        if (ovf_count_q != '1) ovf_count_d = ovf_count_q + ERR_CNT_W'(1);
      end
    end else if (valid_q && word.word_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      ovf_count_d  = '0;
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q         <= '0;
      bcnt_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ovf_count_q  <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bcnt_q       <= bcnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ovf_count_q  <= ovf_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign word.word_data  = data_q;
  assign word.word_valid = valid_q;
  assign ovf_count       = ovf_count_q;
  assign ovf_sticky      = ovf_sticky_q;

endmodule

// File: rtl/state_code_decoder.sv
// Receive side of the 2-bit state-code link: tracks transmitter protocol,
// recovers serial bits from S/T toggles and hands them to the word packer.
module state_code_decoder
  import state_code_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           code_in,
  input  logic                 clear,
  state_code_decoder_if.master word,
  output logic                 locked,
  output logic                 err,
  output logic                 resync,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] ovf_count,
  output logic                 ovf_sticky
);

  dec_state_e           state_q, state_d;
  logic [1:0]           prev_code_q, prev_code_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 resync_q, resync_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 bit_val, bit_en, flush, err_entry;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    resync_d = 1'b0;
    bit_en   = 1'b0;
    bit_val  = 1'b0;
    flush    = 1'b0;

    unique case (state_q)
      HUNT:  if (code_in == CODE_I) state_d = ARMED;
      ARMED: begin
        if (code_in == CODE_S)      state_d = RUN;
        else if (code_in != CODE_I) state_d = ERR;
      end
      RUN: begin
        if (code_in == CODE_I) begin
          state_d  = ARMED;
          resync_d = 1'b1;
          flush    = 1'b1;
        end else if (code_in == CODE_NONE) begin
          state_d = ERR;
        end else if (is_data_code(prev_code_q)) begin
          // A toggle between S and T encodes a 1; a repeat encodes a 0.
          bit_en  = 1'b1;
          bit_val = (code_in != prev_code_q);
        end
      end
      ERR:     if (code_in == CODE_I) state_d = ARMED;
      default: state_d = HUNT;
    endcase

    err_entry = (state_d == ERR) && (state_q != ERR);
    if (err_entry) flush = 1'b1;

    err_count_d = err_count_q;
    if (clear)                                 err_count_d = '0;
    else if (err_entry && err_count_q != '1)   err_count_d = err_count_q + ERR_CNT_W'(1);

    prev_code_d = code_in;
    locked_d    = (state_d == RUN);
    err_d       = (state_d == ERR);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_code_q <= CODE_NONE;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      resync_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_code_q <= prev_code_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      resync_q    <= resync_d;
      err_count_q <= err_count_d;
    end
  end

  state_code_packer #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .bit_val    (bit_val),
    .bit_en     (bit_en),
    .flush      (flush),
    .clear      (clear),
    .word       (word),
    .ovf_count  (ovf_count),
    .ovf_sticky (ovf_sticky)
  );

  assign locked    = locked_q;
  assign err       = err_q;
  assign resync    = resync_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_state_code_decoder.sv
// Self-checking bench for state_code_decoder: a decode table, directed corner
// sequences, then random codes against a bit-queue reference model.
module tb_state_code_decoder;
  import state_code_pkg::*;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  localparam int P_HUNT  = 0;
  localparam int P_ARMED = 1;
  localparam int P_RUN   = 2;
  localparam int P_ERR   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [1:0]    code_in;
  logic          locked, err, resync, ovf_sticky;
  logic [CW-1:0] err_count, ovf_count;

  state_code_decoder_if #(.WIDTH(W)) word_if ();

  state_code_decoder #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .clear      (clear),
    .word       (word_if.master),
    .locked     (locked),
    .err        (err),
    .resync     (resync),
    .err_count  (err_count),
    .ovf_count  (ovf_count),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fails = 0;
  logic [1:0] tx_code;

  // Reference model: protocol phase plus a queue of bits recovered so far.
  int          m_phase;
  bit          m_bits[$];
  logic [1:0]  m_prev;
  bit          m_held_valid;
  logic [W-1:0] m_held_word;
  int          m_err_cnt, m_ovf_cnt;
  bit          m_sticky, m_resync;

  typedef struct {
    logic [1:0]   code;
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_locked;
    logic         exp_err;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = P_HUNT;
    m_bits.delete();
    m_prev       = CODE_NONE;
    m_held_valid = 1'b0;
    m_held_word  = '0;
    m_err_cnt    = 0;
    m_ovf_cnt    = 0;
    m_sticky     = 1'b0;
    m_resync     = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] c, input bit r, input bit clr);
    int           next_phase;
    bit           got_word;
    logic [63:0]  acc;
    logic [W-1:0] w;
    next_phase = m_phase;
    got_word   = 1'b0;
    w          = '0;
    m_resync   = 1'b0;
    case (m_phase)
      P_HUNT:  if (c == CODE_I) next_phase = P_ARMED;
      P_ARMED: begin
        if (c == CODE_S)      next_phase = P_RUN;
        else if (c != CODE_I) next_phase = P_ERR;
      end
      P_RUN: begin
        if (c == CODE_I) begin
          next_phase = P_ARMED;
          m_resync   = 1'b1;
          m_bits.delete();
        end else if (c == CODE_NONE) begin
          next_phase = P_ERR;
        end else begin
          m_bits.push_back(c != m_prev);
          if (m_bits.size() == W) begin
            acc = 0;
            for (int i = 0; i < W; i++) if (m_bits[i]) acc = acc + (64'd1 << i);
            w        = acc[W-1:0];
            got_word = 1'b1;
            m_bits.delete();
          end
        end
      end
      default: if (c == CODE_I) next_phase = P_ARMED;
    endcase
    if (next_phase == P_ERR && m_phase != P_ERR) begin
      m_bits.delete();
      if (m_err_cnt < CMAX) m_err_cnt++;
    end
    m_phase = next_phase;
    if (got_word) begin
      if (!m_held_valid || r) begin
        m_held_word  = w;
        m_held_valid = 1'b1;
      end else begin
        if (m_ovf_cnt < CMAX) m_ovf_cnt++;
        m_sticky = 1'b1;
      end
    end else if (m_held_valid && r) begin
      m_held_valid = 1'b0;
    end
    if (clr) begin
      m_err_cnt = 0;
      m_ovf_cnt = 0;
      m_sticky  = 1'b0;
    end
    m_prev = c;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step(input logic [1:0] c, input bit r, input bit clr);
    code_in            = c;
    word_if.word_ready = r;
    clear              = clr;
    @(posedge clk);
    #1;
    model_step(c, r, clr);
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    code_in            = CODE_NONE;
    word_if.word_ready = 1'b0;
    clear              = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic tx_sync(input bit r);
    step(CODE_I, r, 1'b0);
    tx_code = CODE_S;
    step(CODE_S, r, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      if (v[i]) tx_code = (tx_code == CODE_S) ? CODE_T : CODE_S;
      step(tx_code, r, 1'b0);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " valid"},   {31'd0, word_if.word_valid}, {31'd0, m_held_valid});
    check({tag, " data"},    32'(word_if.word_data),      32'(m_held_word));
    check({tag, " locked"},  {31'd0, locked},             {31'd0, m_phase == P_RUN});
    check({tag, " err"},     {31'd0, err},                {31'd0, m_phase == P_ERR});
    check({tag, " resync"},  {31'd0, resync},             {31'd0, m_resync});
    check({tag, " err_cnt"}, 32'(err_count),              32'(m_err_cnt));
    check({tag, " ovf_cnt"}, 32'(ovf_count),              32'(m_ovf_cnt));
    check({tag, " sticky"},  {31'd0, ovf_sticky},         {31'd0, m_sticky});
  endtask

  initial begin
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[10] = '{2'b10, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
    tx_code = CODE_S;

    // Reset values
    do_reset();
    check("rst valid",   {31'd0, word_if.word_valid}, 32'd0);
    check("rst data",    32'(word_if.word_data),      32'd0);
    check("rst locked",  {31'd0, locked},             32'd0);
    check("rst err",     {31'd0, err},                32'd0);
    check("rst resync",  {31'd0, resync},             32'd0);
    check("rst err_cnt", 32'(err_count),              32'd0);
    check("rst ovf_cnt", 32'(ovf_count),              32'd0);
    check("rst sticky",  {31'd0, ovf_sticky},         32'd0);

    // Basic decode table: 0xA5 appears for one cycle then is consumed
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].code, tbl[i].ready, 1'b0);
      check($sformatf("tbl%0d valid", i),  {31'd0, word_if.word_valid}, {31'd0, tbl[i].exp_valid});
      check($sformatf("tbl%0d data", i),   32'(word_if.word_data),      32'(tbl[i].exp_data));
      check($sformatf("tbl%0d locked", i), {31'd0, locked},             {31'd0, tbl[i].exp_locked});
      check($sformatf("tbl%0d err", i),    {31'd0, err},                {31'd0, tbl[i].exp_err});
    end

    // Back-pressure: second word overflows, first word is kept
    do_reset();
    tx_sync(1'b0);
    send_bits(32'h3C, W, 1'b0);
    check("bp first valid", {31'd0, word_if.word_valid}, 32'd1);
    check("bp first data",  32'(word_if.word_data),      32'h3C);
    send_bits(32'h81, W, 1'b0);
    check("bp held data",   32'(word_if.word_data),      32'h3C);
    check("bp ovf_cnt",     32'(ovf_count),              32'd1);
    check("bp sticky",      {31'd0, ovf_sticky},         32'd1);
    step(tx_code, 1'b1, 1'b0);
    check("bp accept valid", {31'd0, word_if.word_valid}, 32'd0);
    check("bp accept data",  32'(word_if.word_data),      32'h3C);

    // Accept and complete on the same edge
    do_reset();
    tx_sync(1'b0);
    send_bits(32'h5A, W, 1'b0);
    send_bits(32'hC3, W - 1, 1'b0);
    check("ac pre data", 32'(word_if.word_data), 32'h5A);
    send_bits(32'hC3 >> (W - 1), 1, 1'b1);
    check("ac valid",   {31'd0, word_if.word_valid}, 32'd1);
    check("ac data",    32'(word_if.word_data),      32'hC3);
    check("ac ovf_cnt", 32'(ovf_count),              32'd0);

    // Illegal codes
    do_reset();
    tx_sync(1'b1);
    send_bits(32'h5, 3, 1'b1);
    step(CODE_NONE, 1'b1, 1'b0);
    check("ill00 err",     {31'd0, err},    32'd1);
    check("ill00 locked",  {31'd0, locked}, 32'd0);
    check("ill00 err_cnt", 32'(err_count),  32'd1);
    step(CODE_I, 1'b1, 1'b0);
    check("ill armed err", {31'd0, err}, 32'd0);
    step(CODE_T, 1'b1, 1'b0);
    check("ill11 err",     {31'd0, err},   32'd1);
    check("ill11 err_cnt", 32'(err_count), 32'd2);
    tx_sync(1'b1);
    check("ill relock locked", {31'd0, locked}, 32'd1);
    check("ill relock err",    {31'd0, err},    32'd0);

    // Resync discards a partial word
    do_reset();
    tx_sync(1'b1);
    send_bits(32'h3, 3, 1'b1);
    step(CODE_I, 1'b1, 1'b0);
    check("rs pulse",  {31'd0, resync}, 32'd1);
    check("rs locked", {31'd0, locked}, 32'd0);
    tx_code = CODE_S;
    step(CODE_S, 1'b1, 1'b0);
    check("rs pulse end", {31'd0, resync}, 32'd0);
    check("rs relock",    {31'd0, locked}, 32'd1);
    send_bits(32'h96, W, 1'b1);
    check("rs word valid", {31'd0, word_if.word_valid}, 32'd1);
    check("rs word data",  32'(word_if.word_data),      32'h96);

    // Asynchronous reset mid-word, away from any clock edge
    do_reset();
    tx_sync(1'b0);
    send_bits(32'h11, W, 1'b0);
    send_bits(32'hF, 4, 1'b0);
    step(CODE_NONE, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("ar valid",   {31'd0, word_if.word_valid}, 32'd0);
    check("ar data",    32'(word_if.word_data),      32'd0);
    check("ar locked",  {31'd0, locked},             32'd0);
    check("ar err",     {31'd0, err},                32'd0);
    check("ar err_cnt", 32'(err_count),              32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clear on the same edge as an error entry
    do_reset();
    tx_sync(1'b1);
    step(CODE_NONE, 1'b1, 1'b0);
    check("clr pre err_cnt", 32'(err_count), 32'd1);
    tx_sync(1'b1);
    step(CODE_NONE, 1'b1, 1'b1);
    check("clr err",     {31'd0, err},   32'd1);
    check("clr err_cnt", 32'(err_count), 32'd0);

    // Error counter saturation
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      step(CODE_I, 1'b0, 1'b0);
      step(CODE_NONE, 1'b0, 1'b0);
      if (k == 100) check("sat mid", 32'(err_count), 32'd100);
    end
    check("sat end", 32'(err_count), 32'(CMAX));

    // Random codes against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int   r;
      logic [1:0] c;
      r = int'($urandom_range(0, 31));
      if (r == 0)      c = CODE_NONE;
      else if (r <= 2) c = CODE_I;
      else             c = CODE_S | 2'($urandom_range(0, 1));
      step(c, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
